// File: rtl/ring_entropy_collector.sv
// ring_entropy_collector: samples the raw ring oscillator output through a
// synchroniser on a programmable divider tick, removes bias with a von Neumann
// extractor, packs the surviving bits into 32-bit words and buffers them in a
// small FIFO that firmware drains over Wishbone.
//
// Bus handshake: a request is (stb & cyc) while ack is low. Ack rises on the
// following cycle for exactly one cycle; read data is registered on the same
// edge, and every register side effect (write, pop, flush) happens on that edge.
module ring_entropy_collector #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic [31:0] wb_adr_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    input  logic        ring_raw,
    output logic        data_valid
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    // bus registers
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    // control / status
    logic        enable_q, enable_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    // sampling path
    logic        sync1_q, sync2_q;
    logic [15:0] cnt_q, cnt_d;
    logic        have_a_q, have_a_d;
    logic        a_q, a_d;
    logic [31:0] word_q, word_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    // fifo
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic          valid_q, valid_d;

    logic        req, wr, rd;
    logic        sel_data, sel_stat, sel_ctrl;
    logic        fifo_empty, fifo_full;
    logic        pop, flush, tick, bit_valid, push;
    logic [31:0] push_word;
    logic [31:0] rdata;

    // Bits of the bus that carry no meaning in this window.
    logic unused_bits;
    assign unused_bits = &{1'b0, wb_adr_i[31:8], wb_dat_i[15:2]};

    // Request decode and register select.
    always_comb begin
        req        = wb_stb_i & wb_cyc_i & ~ack_q;
        wr         = req & wb_we_i & (|wb_sel_i);
        rd         = req & ~wb_we_i;
        sel_data   = (wb_adr_i[7:0] == 8'h00);
        sel_stat   = (wb_adr_i[7:0] == 8'h04);
        sel_ctrl   = (wb_adr_i[7:0] == 8'h08);
        fifo_empty = (level_q == 5'd0);
        fifo_full  = (level_q == DEPTH_L);
        pop        = rd & sel_data & ~fifo_empty;
        flush      = wr & sel_ctrl & wb_dat_i[1];
    end

    // Read mux; unmapped addresses and an empty DATA read return zero.
    always_comb begin
        rdata = 32'h0;
        if (sel_data && !fifo_empty) begin
            rdata = mem_q[rd_ptr_q];
        end else if (sel_stat) begin
            rdata = {15'h0, ovf_q, 6'h0, fifo_full, fifo_empty, 3'h0, level_q};
        end else if (sel_ctrl) begin
            rdata = {div_q, 14'h0, 1'b0, enable_q};
        end
    end

    // Bus response and control register updates.
    always_comb begin
        ack_d    = req;
        dat_d    = rd ? rdata : 32'h0;
        enable_d = enable_q;
        div_d    = div_q;
        if (wr && sel_ctrl) begin
            enable_d = wb_dat_i[0];
            div_d    = wb_dat_i[31:16];
        end
    end

    // Sample divider: counts only while enabled; the count is compared for
    // equality, so lowering the divider below the live count waits for a wrap.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (!enable_q) begin
            cnt_d = 16'h0;
        end else if (cnt_q == div_q) begin
            tick  = 1'b1;
            cnt_d = 16'h0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Von Neumann extractor and bit packer; disable or flush drops partial work.
    always_comb begin
        have_a_d  = have_a_q;
        a_d       = a_q;
        bit_valid = 1'b0;
        word_d    = word_q;
        bitcnt_d  = bitcnt_q;
        push      = 1'b0;
        push_word = {a_q, word_q[31:1]};
        if (!enable_q) begin
            have_a_d = 1'b0;
            a_d      = 1'b0;
        end else if (tick) begin
            if (!have_a_q) begin
                have_a_d = 1'b1;
                a_d      = sync2_q;
            end else begin
                have_a_d  = 1'b0;
                bit_valid = (a_q != sync2_q);
            end
        end
        if (!enable_q || flush) begin
            word_d   = 32'h0;
            bitcnt_d = 5'd0;
        end else if (bit_valid) begin
            if (bitcnt_q == 5'd31) begin
                push     = 1'b1;
                word_d   = 32'h0;
                bitcnt_d = 5'd0;
            end else begin
                word_d   = push_word;
                bitcnt_d = bitcnt_q + 5'd1;
            end
        end
    end

    // FIFO bookkeeping: a pop frees the slot a simultaneous push needs when full.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (wr && sel_stat && wb_dat_i[16]) begin
            ovf_d = 1'b0;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = 5'd0;
        end else begin
            if (push && (!fifo_full || pop)) begin
                mem_d[wr_ptr_q] = push_word;
                wr_ptr_d        = wr_ptr_q + AW'(1);
                level_d         = level_d + 5'd1;
            end else if (push) begin
                ovf_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                level_d  = level_d - 5'd1;
            end
        end
        valid_d = (level_d != 5'd0);
    end

    // Two-flop synchroniser for the asynchronous ring output.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ring_raw;
            sync2_q <= sync1_q;
        end
    end

    // Bus, control and sampling-path state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            enable_q <= 1'b0;
            div_q    <= DIV_RESET;
            ovf_q    <= 1'b0;
            cnt_q    <= 16'h0;
            have_a_q <= 1'b0;
            a_q      <= 1'b0;
            word_q   <= 32'h0;
            bitcnt_q <= 5'd0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            enable_q <= enable_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            have_a_q <= have_a_d;
            a_q      <= a_d;
            word_q   <= word_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // FIFO storage, pointers and the registered not-empty flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 5'd0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_ring_entropy_collector.sv
// Bench for ring_entropy_collector: drives ring_raw bit streams aligned to the
// sample ticks, pushes the words the extractor must produce into exp_q and pops
// them as firmware-style DATA reads return words.
module tb_ring_entropy_collector;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] adr;
    logic        ack;
    logic [31:0] dat_o;
    logic        ring_raw;
    logic        data_valid;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    ring_entropy_collector dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_stb_i   (stb),
        .wb_cyc_i   (cyc),
        .wb_we_i    (we),
        .wb_sel_i   (sel),
        .wb_dat_i   (dat_i),
        .wb_adr_i   (adr),
        .wb_ack_o   (ack),
        .wb_dat_o   (dat_o),
        .ring_raw   (ring_raw),
        .data_valid (data_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = {24'h0, a}; dat_i = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d, output logic k);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = {24'h0, a}; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        d = dat_o; k = ack;
        stb = 1'b0; cyc = 1'b0;
    endtask

    // Entered at a negedge; each value is held for one cycle.
    task automatic drive_pair(input logic a, input logic b);
        ring_raw = a;
        @(negedge clk);
        ring_raw = b;
        @(negedge clk);
    endtask

    task automatic drive_slot(input logic v);
        ring_raw = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic drive_word(input logic [31:0] w, input logic junk);
        logic x;
        for (int i = 0; i < 32; i++) begin
            if (junk && $urandom_range(0, 3) == 0) begin
                x = 1'($urandom_range(0, 1));
                drive_pair(x, x);
            end
            drive_pair(w[i], ~w[i]);
        end
    endtask

    // With divider 0 the first pair after enabling samples the held 0 and is
    // discarded, so the stream that follows starts on a pair boundary.
    task automatic start_collect(input logic [15:0] div);
        @(negedge clk);
        ring_raw = 1'b0;
        wb_write(8'h08, {div, 16'h0001}, 4'hF);
    endtask

    task automatic stop_collect(input logic [15:0] div);
        repeat (4) @(negedge clk);
        wb_write(8'h08, {div, 16'h0000}, 4'hF);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d; logic k;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ack); else n_pass++;
        n_checks++; if (dat_o !== 32'h0) $display("FAIL reset_dat got %h want 0", dat_o); else n_pass++;
        n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", data_valid); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        wb_read(8'h04, d, k);
        n_checks++; if (k !== 1'b1) $display("FAIL reset_read_ack got %b want 1", k); else n_pass++;
        n_checks++; if (d !== 32'h0000_0100) $display("FAIL reset_status got %h want 00000100", d); else n_pass++;
        wb_read(8'h08, d, k);
        n_checks++; if (d !== 32'h000F_0000) $display("FAIL reset_control got %h want 000f0000", d); else n_pass++;
    endtask

    task automatic test_wishbone();
        logic [31:0] d; logic k; logic a1, a2;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
        @(posedge clk); @(negedge clk); a1 = ack;
        @(posedge clk); @(negedge clk); a2 = ack;
        stb = 1'b0; cyc = 1'b0;
        n_checks++; if (a1 !== 1'b1) $display("FAIL ack_first got %b want 1", a1); else n_pass++;
        n_checks++; if (a2 !== 1'b0) $display("FAIL ack_single got %b want 0", a2); else n_pass++;
        wb_read(8'h10, d, k);
        n_checks++; if (k !== 1'b1) $display("FAIL unmapped_ack got %b want 1", k); else n_pass++;
        n_checks++; if (d !== 32'h0) $display("FAIL unmapped_read got %h want 0", d); else n_pass++;
        wb_write(8'h08, 32'h1234_0001, 4'h0);
        wb_read(8'h08, d, k);
        n_checks++; if (d !== 32'h000F_0000) $display("FAIL sel_zero_write got %h want 000f0000", d); else n_pass++;
        wb_write(8'h10, 32'hFFFF_FFFF, 4'hF);
        wb_write(8'h00, 32'hDEAD_BEEF, 4'hF);
        wb_read(8'h08, d, k);
        n_checks++; if (d !== 32'h000F_0000) $display("FAIL unmapped_write got %h want 000f0000", d); else n_pass++;
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0100) $display("FAIL data_write got %h want 00000100", d); else n_pass++;
        wb_write(8'h08, 32'h0007_0002, 4'hF);
        wb_read(8'h08, d, k);
        n_checks++; if (d !== 32'h0007_0000) $display("FAIL flush_reads_zero got %h want 00070000", d); else n_pass++;
    endtask

    task automatic test_patterns();
        logic [31:0] d, e, w; logic k;
        start_collect(16'd0);
        for (int i = 0; i < 32; i++) drive_pair(1'b0, 1'b1);
        exp_q.push_back(32'h0000_0000);
        stop_collect(16'd0);
        start_collect(16'd0);
        for (int i = 0; i < 32; i++) drive_pair(1'b1, 1'b0);
        exp_q.push_back(32'hFFFF_FFFF);
        stop_collect(16'd0);
        start_collect(16'd0);
        w = $urandom();
        drive_word(w, 1'b1);
        exp_q.push_back(w);
        stop_collect(16'd0);
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0003) $display("FAIL patterns_status got %h want 00000003", d); else n_pass++;
        while (exp_q.size() != 0) begin
            wb_read(8'h00, d, k);
            e = exp_q.pop_front();
            n_checks++; if (d !== e) $display("FAIL patterns_word got %h want %h", d, e); else n_pass++;
        end
        start_collect(16'd0);
        ring_raw = 1'b1;
        repeat (200) @(negedge clk);
        stop_collect(16'd0);
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0100) $display("FAIL constant_no_words got %h want 00000100", d); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] d, e, w; logic k;
        start_collect(16'd0);
        for (int n = 0; n < 5; n++) begin
            w = $urandom();
            drive_word(w, 1'b0);
            if (n < 4) exp_q.push_back(w);
        end
        stop_collect(16'd0);
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0001_0204) $display("FAIL overflow_status got %h want 00010204", d); else n_pass++;
        n_checks++; if (data_valid !== 1'b1) $display("FAIL overflow_valid got %b want 1", data_valid); else n_pass++;
        wb_write(8'h04, 32'h0000_FFFF, 4'hF);
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0001_0204) $display("FAIL ovf_kept_bit16_zero got %h want 00010204", d); else n_pass++;
        wb_write(8'h04, 32'h0001_0000, 4'hF);
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0204) $display("FAIL ovf_w1c got %h want 00000204", d); else n_pass++;
        while (exp_q.size() != 0) begin
            wb_read(8'h00, d, k);
            e = exp_q.pop_front();
            n_checks++; if (d !== e) $display("FAIL overflow_order got %h want %h", d, e); else n_pass++;
        end
        wb_read(8'h00, d, k);
        n_checks++; if (d !== 32'h0) $display("FAIL empty_read got %h want 0", d); else n_pass++;
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0100) $display("FAIL empty_read_level got %h want 00000100", d); else n_pass++;
    endtask

    // The fifth word completes on the same edge as the DATA read request.
    task automatic test_back_to_back();
        logic [31:0] d, e, w4; logic k;
        start_collect(16'd0);
        for (int n = 0; n < 4; n++) begin
            e = $urandom();
            drive_word(e, 1'b0);
            exp_q.push_back(e);
        end
        w4 = $urandom();
        drive_word(w4, 1'b0);
        wb_read(8'h00, d, k);
        e = exp_q.pop_front();
        exp_q.push_back(w4);
        n_checks++; if (d !== e) $display("FAIL b2b_pop_word got %h want %h", d, e); else n_pass++;
        stop_collect(16'd0);
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0204) $display("FAIL b2b_status got %h want 00000204", d); else n_pass++;
        while (exp_q.size() != 0) begin
            wb_read(8'h00, d, k);
            e = exp_q.pop_front();
            n_checks++; if (d !== e) $display("FAIL b2b_order got %h want %h", d, e); else n_pass++;
        end
    endtask

    // Divider 3: one tick per four cycles, so each stream value is held for four.
    task automatic test_divider();
        logic [31:0] d, e, w; logic k;
        start_collect(16'd3);
        w = $urandom();
        for (int i = 0; i < 31; i++) begin
            drive_slot(w[i]);
            drive_slot(~w[i]);
        end
        drive_slot(w[31]);
        ring_raw = ~w[31];
        repeat (3) @(negedge clk);
        n_checks++; if (data_valid !== 1'b0) $display("FAIL div_no_early_push got %b want 0", data_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (data_valid !== 1'b1) $display("FAIL div_push_on_tick got %b want 1", data_valid); else n_pass++;
        exp_q.push_back(w);
        stop_collect(16'd3);
        start_collect(16'd3);
        for (int i = 0; i < 10; i++) drive_slot(1'($urandom_range(0, 1)));
        stop_collect(16'd3);
        start_collect(16'd3);
        w = $urandom();
        for (int i = 0; i < 32; i++) begin
            drive_slot(w[i]);
            drive_slot(~w[i]);
        end
        exp_q.push_back(w);
        stop_collect(16'd3);
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0002) $display("FAIL div_status got %h want 00000002", d); else n_pass++;
        while (exp_q.size() != 0) begin
            wb_read(8'h00, d, k);
            e = exp_q.pop_front();
            n_checks++; if (d !== e) $display("FAIL div_word got %h want %h", d, e); else n_pass++;
        end
    endtask

    task automatic test_flush();
        logic [31:0] d; logic k;
        start_collect(16'd0);
        drive_word($urandom(), 1'b0);
        for (int i = 0; i < 10; i++) drive_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        n_checks++; if (data_valid !== 1'b1) $display("FAIL flush_pre_valid got %b want 1", data_valid); else n_pass++;
        wb_write(8'h08, 32'h0000_0003, 4'hF);
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0100) $display("FAIL flush_status got %h want 00000100", d); else n_pass++;
        n_checks++; if (data_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", data_valid); else n_pass++;
        stop_collect(16'd0);
        wb_read(8'h00, d, k);
        n_checks++; if (d !== 32'h0) $display("FAIL flush_data got %h want 0", d); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic k;
        start_collect(16'd0);
        drive_word($urandom(), 1'b0);
        drive_word($urandom(), 1'b0);
        for (int i = 0; i < 10; i++) drive_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0002) $display("FAIL mid_pre_status got %h want 00000002", d); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (data_valid !== 1'b0) $display("FAIL mid_async_valid got %b want 0", data_valid); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (ack !== 1'b0) $display("FAIL mid_ack got %b want 0", ack); else n_pass++;
        n_checks++; if (dat_o !== 32'h0) $display("FAIL mid_dat got %h want 0", dat_o); else n_pass++;
        rst = 1'b0;
        wb_read(8'h04, d, k);
        n_checks++; if (d !== 32'h0000_0100) $display("FAIL mid_status got %h want 00000100", d); else n_pass++;
        wb_read(8'h08, d, k);
        n_checks++; if (d !== 32'h000F_0000) $display("FAIL mid_control got %h want 000f0000", d); else n_pass++;
        wb_read(8'h00, d, k);
        n_checks++; if (d !== 32'h0) $display("FAIL mid_data got %h want 0", d); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = 32'h0; adr = 32'h0; ring_raw = 1'b0;
        test_reset();
        test_wishbone();
        test_patterns();
        test_overflow();
        test_back_to_back();
        test_divider();
        test_flush();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
